// File: rtl/note_recorder.sv
// note_recorder: records drum-key presses into three beat-indexed lanes plus a saturating note count.
// One slot commits per beat_tick; all outputs are registered and a commit is visible the cycle after its tick.
module note_recorder #(
   parameter int LANE_LEN = 100,
   parameter int COUNT_W  = 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                stop,
   input  logic                beat_tick,
   input  logic [2:0]          keys,
   output logic                recording,
   output logic                done,
   output logic [6:0]          beat_index,
   output logic [LANE_LEN-1:0] output_red,
   output logic [LANE_LEN-1:0] output_yellow,
   output logic [LANE_LEN-1:0] output_blue,
   output logic [COUNT_W-1:0]  output_total_notes
);
   typedef enum logic [1:0] {IDLE, ARMED, RECORDING, DONE} state_t;

   state_t              state;
   logic [2:0]          keys_q;
   logic [2:0]          pending;
   logic [2:0]          rise;
   logic [2:0]          commit;
   logic [1:0]          pop;
   logic [COUNT_W:0]    sum;
   logic [COUNT_W-1:0]  count_next;
   logic [6:0]          slot;
   logic [6:0]          index_next;
   logic [LANE_LEN-1:0] slot_mask;

   always_comb begin
      rise       = keys & ~keys_q;
      // A rising edge coincident with the tick still belongs to the closing window.
      commit     = pending | rise;
      pop        = {1'b0, commit[0]} + {1'b0, commit[1]} + {1'b0, commit[2]};
      sum        = {1'b0, output_total_notes} + {{(COUNT_W-1){1'b0}}, pop};
      count_next = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
      slot       = 7'(LANE_LEN - 1) - beat_index;
      slot_mask  = {{(LANE_LEN-1){1'b0}}, 1'b1} << slot;
      index_next = beat_index + 7'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state              <= IDLE;
         recording          <= 1'b0;
         done               <= 1'b0;
         beat_index         <= '0;
         output_red         <= '0;
         output_yellow      <= '0;
         output_blue        <= '0;
         output_total_notes <= '0;
         pending            <= '0;
         keys_q             <= 3'b111;
      end else begin
         keys_q <= keys;
         case (state)
            IDLE, DONE: begin
               if (start && !stop) begin
                  state              <= ARMED;
                  recording          <= 1'b0;
                  done               <= 1'b0;
                  beat_index         <= '0;
                  output_red         <= '0;
                  output_yellow      <= '0;
                  output_blue        <= '0;
                  output_total_notes <= '0;
                  pending            <= '0;
               end
            end
            ARMED: begin
               if (stop) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (beat_tick) begin
                  state     <= RECORDING;
                  recording <= 1'b1;
                  pending   <= '0;
               end
            end
            RECORDING: begin
               if (beat_tick) begin
                  if (commit[2]) output_red    <= output_red    | slot_mask;
                  if (commit[1]) output_yellow <= output_yellow | slot_mask;
                  if (commit[0]) output_blue   <= output_blue   | slot_mask;
                  output_total_notes <= count_next;
                  beat_index         <= index_next;
                  pending            <= '0;
                  if (stop || index_next == 7'(LANE_LEN)) begin
                     state     <= DONE;
                     recording <= 1'b0;
                     done      <= 1'b1;
                  end
               end else if (stop) begin
                  pending   <= '0;
                  state     <= DONE;
                  recording <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  pending <= pending | rise;
               end
            end
            default: begin
               state     <= IDLE;
               recording <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: table-driven vectors, hand sequences, and a per-cycle scoreboard against a behavioural model.
module tb_note_recorder;
   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic         stop = 1'b0;
   logic         beat_tick = 1'b0;
   logic [2:0]   keys = 3'b111;
   logic         recording;
   logic         done;
   logic [6:0]   beat_index;
   logic [99:0]  output_red;
   logic [99:0]  output_yellow;
   logic [99:0]  output_blue;
   logic [7:0]   output_total_notes;

   int checks = 0;
   int failures = 0;

   note_recorder #(.LANE_LEN(100), .COUNT_W(8)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .beat_tick(beat_tick),
      .keys(keys), .recording(recording), .done(done), .beat_index(beat_index),
      .output_red(output_red), .output_yellow(output_yellow), .output_blue(output_blue),
      .output_total_notes(output_total_notes)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [99:0] r, y, b;
      int          cnt;
      int          idx;
      logic        rec, dn;
   } exp_t;

   exp_t sb_q[$];

   // Behavioural model: 0 idle, 1 armed, 2 recording, 3 done
   int          m_state = 0;
   logic [99:0] m_r = '0, m_y = '0, m_b = '0;
   int          m_cnt = 0;
   int          m_idx = 0;
   logic [2:0]  m_pend = '0, m_kq = 3'b111;

   task automatic model_update(input logic rn, st, sp, bt, input logic [2:0] k);
      logic [2:0] rise, c;
      rise = k & ~m_kq;
      if (!rn) begin
         m_state = 0; m_r = '0; m_y = '0; m_b = '0; m_cnt = 0; m_idx = 0;
         m_pend = '0; m_kq = 3'b111;
         return;
      end
      case (m_state)
         0, 3: if (st && !sp) begin
            m_state = 1; m_r = '0; m_y = '0; m_b = '0; m_cnt = 0; m_idx = 0; m_pend = '0;
         end
         1: if (sp) m_state = 3;
            else if (bt) begin m_state = 2; m_pend = '0; end
         2: if (bt) begin
               c = m_pend | rise;
               if (c[2]) m_r[99 - m_idx] = 1'b1;
               if (c[1]) m_y[99 - m_idx] = 1'b1;
               if (c[0]) m_b[99 - m_idx] = 1'b1;
               m_cnt = m_cnt + int'(c[0]) + int'(c[1]) + int'(c[2]);
               if (m_cnt > 255) m_cnt = 255;
               m_idx = m_idx + 1;
               m_pend = '0;
               if (sp || m_idx == 100) m_state = 3;
            end else if (sp) begin
               m_pend = '0; m_state = 3;
            end else m_pend = m_pend | rise;
         default: m_state = 0;
      endcase
      m_kq = k;
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Drive one cycle, push the model's expectation, then compare after the edge.
   task automatic step(input logic rn, st, sp, bt, input logic [2:0] k);
      exp_t e;
      resetn = rn; start = st; stop = sp; beat_tick = bt; keys = k;
      model_update(rn, st, sp, bt, k);
      e.r = m_r; e.y = m_y; e.b = m_b; e.cnt = m_cnt; e.idx = m_idx;
      e.rec = (m_state == 2); e.dn = (m_state == 3);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (output_red !== e.r || output_yellow !== e.y || output_blue !== e.b ||
          output_total_notes !== 8'(e.cnt) || beat_index !== 7'(e.idx) ||
          recording !== e.rec || done !== e.dn) begin
         failures++;
         $display("FAIL scoreboard t=%0t got rec=%b done=%b idx=%0d cnt=%0d r=%h y=%h b=%h exp rec=%b done=%b idx=%0d cnt=%0d r=%h y=%h b=%h",
                  $time, recording, done, beat_index, output_total_notes, output_red, output_yellow, output_blue,
                  e.rec, e.dn, e.idx, e.cnt, e.r, e.y, e.b);
      end
   endtask

   typedef struct {
      logic       st, sp, bt;
      logic [2:0] k;
      logic       rec, dn;
      logic [6:0] idx;
      logic [7:0] cnt;
   } vec_t;

   vec_t vt[6];

   initial begin
      // start, arming tick, empty slot 0 with keys held, release/re-press red, commit slot 1
      vt[0] = '{1, 0, 0, 3'b111, 0, 0, 7'd0, 8'd0};
      vt[1] = '{0, 0, 1, 3'b111, 1, 0, 7'd0, 8'd0};
      vt[2] = '{0, 0, 1, 3'b111, 1, 0, 7'd1, 8'd0};
      vt[3] = '{0, 0, 0, 3'b011, 1, 0, 7'd1, 8'd0};
      vt[4] = '{0, 0, 0, 3'b111, 1, 0, 7'd1, 8'd0};
      vt[5] = '{0, 0, 1, 3'b111, 1, 0, 7'd2, 8'd1};

      step(0, 0, 0, 0, 3'b111);
      step(0, 0, 0, 0, 3'b111);
      chk("reset_idx", beat_index, 0);
      chk("reset_flags", {recording, done}, 0);
      chk("reset_lanes", output_red | output_yellow | output_blue, 0);
      step(1, 0, 0, 0, 3'b111);

      for (int i = 0; i < 6; i++) begin
         step(1, vt[i].st, vt[i].sp, vt[i].bt, vt[i].k);
         chk($sformatf("vec%0d_rec", i), recording, vt[i].rec);
         chk($sformatf("vec%0d_done", i), done, vt[i].dn);
         chk($sformatf("vec%0d_idx", i), beat_index, vt[i].idx);
         chk($sformatf("vec%0d_cnt", i), output_total_notes, vt[i].cnt);
      end
      chk("held_red_slot0", output_red[99], 0);
      chk("repress_red_slot1", output_red[98], 1);

      // Mid-recording reset
      step(0, 0, 0, 0, 3'b000);
      chk("midrec_reset", {recording, done, beat_index, output_total_notes}, 0);
      chk("midrec_reset_lanes", output_red | output_yellow | output_blue, 0);

      // Multiple presses in one window
      step(1, 1, 0, 0, 3'b000);
      step(1, 0, 0, 1, 3'b000);
      step(1, 0, 0, 0, 3'b001);
      step(1, 0, 0, 0, 3'b000);
      step(1, 0, 0, 0, 3'b001);
      step(1, 0, 0, 0, 3'b010);
      step(1, 0, 0, 0, 3'b000);
      step(1, 0, 0, 1, 3'b000);
      chk("multi_lanes99", {output_red[99], output_yellow[99], output_blue[99]}, 3'b011);
      chk("multi_cnt", output_total_notes, 2);
      chk("multi_idx", beat_index, 1);

      // Edge coincident with tick, then edge right after a tick
      step(1, 0, 0, 1, 3'b100);
      step(1, 0, 0, 0, 3'b000);
      step(1, 0, 0, 1, 3'b000);
      step(1, 0, 0, 0, 3'b100);
      step(1, 0, 0, 1, 3'b100);
      chk("edge_red_slots", output_red[98:96], 3'b101);
      chk("edge_idx", beat_index, 4);
      chk("edge_cnt", output_total_notes, 4);

      // Full song with all lanes every window
      step(0, 0, 0, 0, 3'b000);
      step(1, 1, 0, 0, 3'b000);
      step(1, 0, 0, 1, 3'b000);
      for (int i = 0; i < 100; i++) begin
         step(1, 0, 0, 0, 3'b111);
         step(1, 0, 0, 1, 3'b000);
         if (i == 98) chk("full_not_done_99", done, 0);
      end
      chk("full_done", {recording, done}, 2'b01);
      chk("full_lanes", output_red & output_yellow & output_blue, {100{1'b1}});
      chk("full_cnt_sat", output_total_notes, 255);
      chk("full_idx", beat_index, 100);
      step(1, 0, 0, 0, 3'b111);
      step(1, 0, 0, 1, 3'b000);
      chk("after_done_cnt", output_total_notes, 255);
      chk("after_done_idx", beat_index, 100);

      // start+stop in DONE, then start alone
      step(1, 1, 1, 0, 3'b000);
      chk("startstop_done", {recording, done}, 2'b01);
      step(1, 1, 0, 0, 3'b000);
      chk("rearm_flags", {recording, done}, 0);
      chk("rearm_lanes", output_red | output_yellow | output_blue, 0);
      chk("rearm_cnt", output_total_notes, 0);

      // Ten beats, stop coinciding with the tenth tick
      step(1, 0, 0, 1, 3'b000);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 0, 3'b100);
         step(1, 0, (i == 9), 1, 3'b000);
      end
      chk("stop10_done", {recording, done}, 2'b01);
      chk("stop10_idx", beat_index, 10);
      chk("stop10_high", output_red[99:90], 10'h3ff);
      chk("stop10_low", output_red[89:0], 0);
      chk("stop10_cnt", output_total_notes, 10);

      // stop alone discards pending
      step(1, 1, 0, 0, 3'b000);
      step(1, 0, 0, 1, 3'b000);
      step(1, 0, 0, 0, 3'b001);
      step(1, 0, 1, 0, 3'b001);
      chk("stop_pending_done", done, 1);
      chk("stop_pending_blue", output_blue, 0);
      chk("stop_pending_cnt", output_total_notes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/note_recorder.md
# note_recorder

Captures a player-performed chart from the three drum keys and packs it into the same three-lane note format that the song loader feeds into note storage, so a recorded song can be replayed as a chart. Sits beside the song loader: key presses come in, and per-beat lane bits plus a total-note count go out. One beat slot is committed per beat tick from the song-speed counter.

## Interface
- LANE_LEN, 100, number of beat slots per lane (bit width of each lane output)
- COUNT_W, 8, width of the total-note counter

- clk  input  1  system clock (CLOCK_50 domain)
- resetn  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new recording
- stop  input  1  one-cycle pulse; ends recording early
- beat_tick  input  1  one-cycle pulse marking the end of a beat window
- keys  input  3  active-high key levels, already synchronous to clk; [2]=red, [1]=yellow, [0]=blue
- recording  output  1  high while in RECORDING
- done  output  1  high while in DONE
- beat_index  output  7  next beat slot to be written (0..LANE_LEN)
- output_red  output  LANE_LEN  recorded red lane
- output_yellow  output  LANE_LEN  recorded yellow lane
- output_blue  output  LANE_LEN  recorded blue lane
- output_total_notes  output  COUNT_W  number of set bits across all three lanes, saturating

## Operation
- States: IDLE, ARMED, RECORDING, DONE. Reset -> IDLE; lanes, beat_index, count, pending all 0; key history register set to 3'b111, so keys held through reset do not register a press.
- Edge detect: rise = keys & ~keys_q; keys_q <= keys every cycle in every state.
- IDLE: start -> ARMED; clears lanes, count, beat_index, pending.
- DONE: lanes and count held; start -> ARMED with the same clears as in IDLE.
- ARMED: waits for the first beat_tick. Presses are ignored, so the first window is aligned to the beat. beat_tick -> RECORDING with pending cleared; nothing is committed. stop -> DONE with all lanes zero.
- RECORDING:
  - pending <= pending | rise (sticky per lane within a window).
  - On beat_tick: commit c = pending | rise into bit (LANE_LEN-1-beat_index) of red/yellow/blue = c[2]/c[1]/c[0]. beat 0 is the MSB.
  - On the same commit: count += popcount(c), saturating at 2^COUNT_W-1; beat_index += 1; pending <= 0.
  - When beat_index reaches LANE_LEN on a commit -> DONE.
  - stop without beat_tick: pending is discarded; unwritten slots stay 0; -> DONE.
- Priority:
  - stop and beat_tick in the same cycle: commit first, then DONE.
  - start and stop in the same cycle: stop wins; start is ignored.
  - start in ARMED or RECORDING is ignored.
- Multiple presses of one lane within a window produce a single note. Simultaneous lanes in one window are all recorded, with popcount up to 3.
- resetn low in any state forces the full reset values at the next edge and discards a partial recording.

## Timing
- All outputs are registered.
- A commit triggered by beat_tick high in cycle N is visible on the lane outputs, output_total_notes and beat_index from cycle N+1.
- A press whose rising edge falls in the same cycle as beat_tick belongs to the closing window. A rising edge in cycle N+1 belongs to the next window.
- recording and done reflect the state register and change one cycle after the causing pulse. done rises in the same cycle the final (LANE_LEN-th) commit becomes visible.
- Input requirements:
  - beat_tick must be a single-cycle pulse; the integrator converts the level-type counter reset to a pulse upstream.
  - start and stop are single-cycle pulses.
- Throughput: one beat slot per beat_tick, with no minimum spacing beyond one idle cycle between ticks.

## Test plan
- Reset with keys=3'b111 held, then start, one tick, release and re-press red, tick -> output_red[99]=0, output_red[98]=1, count=1, beat_index=2.
- start, tick, press blue twice and yellow once inside one window, tick -> blue[99]=1, yellow[99]=1, red[99]=0, count=2, beat_index=1.
- Red rising edge in the same cycle as beat_tick -> recorded in the closing slot. Rising edge the cycle after -> recorded in the next slot.
- Press all three keys every window for 100 ticks -> all lanes all ones; count saturates at 255, not 300; done=1, recording=0; a further tick changes nothing.
- 10 beats, then stop coinciding with a tick -> the 10th slot is committed, then DONE, beat_index=10, bits [89:0] all 0. stop alone with pending presses -> pending discarded.
- In DONE, assert start and stop together -> remains in DONE. start alone -> ARMED, lanes=0, count=0. Mid-RECORDING resetn=0 -> IDLE with all outputs 0 next cycle.
